// File: rtl/uart_cmd_parser.sv
// Frames UART bytes into SOF/CMD/LEN/payload/XOR-checksum packets, holds a validated command
// for a valid/ready consumer and exposes the payload through a registered read port.
module uart_cmd_parser #(
   parameter int unsigned ClkFrequency  = 100000000,
   parameter int unsigned MaxLen        = 16,
   parameter int unsigned TimeoutCycles = 1000000,
   parameter logic [7:0]  Sof           = 8'hAA
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_data_ready,
   input  logic [7:0] rx_data,
   output logic       cmd_valid,
   input  logic       cmd_ready,
   output logic [7:0] cmd_code,
   output logic [4:0] cmd_len,
   input  logic [3:0] rd_addr,
   output logic [7:0] rd_data,
   output logic       frame_err,
   output logic [1:0] err_code,
   output logic       busy
);

   localparam int unsigned TmoW = $clog2(TimeoutCycles);
   localparam logic [TmoW-1:0] TmoTerm = TmoW'(TimeoutCycles - 1);

   if (ClkFrequency == 0 || MaxLen < 1 || MaxLen > 16 || TimeoutCycles < 2) begin : gParamCheck
      $error("uart_cmd_parser: parameter out of range");
   end

   typedef enum logic [2:0] {StIdle, StCmd, StLen, StPayload, StChk, StHold} state_e;

   state_e          stateQ, stateD;
   logic [7:0]      codeQ, codeD;
   logic [4:0]      lenQ, lenD;
   logic [3:0]      cntQ, cntD;
   logic [7:0]      chkQ, chkD;
   logic [TmoW-1:0] tmoQ, tmoD;
   logic            errQ, errD;
   logic [1:0]      errCodeQ, errCodeD;
   logic [7:0]      rdDataQ;
   logic            bufWe;
   logic [7:0]      bufMem [16];

   always_comb begin
      stateD   = stateQ;
      codeD    = codeQ;
      lenD     = lenQ;
      cntD     = cntQ;
      chkD     = chkQ;
      tmoD     = '0;
      errD     = 1'b0;
      errCodeD = errCodeQ;
      bufWe    = 1'b0;

      unique case (stateQ)
         StIdle: begin
            if (rx_data_ready && rx_data == Sof) stateD = StCmd;
         end
         StCmd: begin
            if (rx_data_ready) begin
               codeD  = rx_data;
               chkD   = rx_data;
               stateD = StLen;
            end
         end
         StLen: begin
            if (rx_data_ready) begin
               chkD = chkQ ^ rx_data;
               if (rx_data > 8'(MaxLen)) begin
                  errD     = 1'b1;
                  errCodeD = 2'd2;
                  stateD   = StIdle;
               end else if (rx_data == 8'd0) begin
                  lenD   = 5'd0;
                  stateD = StChk;
               end else begin
                  lenD   = rx_data[4:0];
                  cntD   = 4'd0;
                  stateD = StPayload;
               end
            end
         end
         StPayload: begin
            if (rx_data_ready) begin
               bufWe = 1'b1;
               chkD  = chkQ ^ rx_data;
               cntD  = cntQ + 4'd1;
               if ({1'b0, cntQ} == lenQ - 5'd1) stateD = StChk;
            end
         end
         StChk: begin
            if (rx_data_ready) begin
               if (rx_data == chkQ) begin
                  stateD = StHold;
               end else begin
                  errD     = 1'b1;
                  errCodeD = 2'd1;
                  stateD   = StIdle;
               end
            end
         end
         StHold: begin
            // Bytes cannot be buffered while a command is pending; report them as overrun.
            if (rx_data_ready) begin
               errD     = 1'b1;
               errCodeD = 2'd0;
            end
            if (cmd_ready) stateD = StIdle;
         end
         default: stateD = StIdle;
      endcase

      // A strobe on the terminal cycle wins over the timeout.
      if (stateQ inside {StCmd, StLen, StPayload, StChk} && !rx_data_ready) begin
         if (tmoQ == TmoTerm) begin
            errD     = 1'b1;
            errCodeD = 2'd3;
            stateD   = StIdle;
         end else begin
            tmoD = tmoQ + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stateQ   <= StIdle;
         codeQ    <= 8'd0;
         lenQ     <= 5'd0;
         cntQ     <= 4'd0;
         chkQ     <= 8'd0;
         tmoQ     <= '0;
         errQ     <= 1'b0;
         errCodeQ <= 2'd0;
         rdDataQ  <= 8'd0;
      end else begin
         stateQ   <= stateD;
         codeQ    <= codeD;
         lenQ     <= lenD;
         cntQ     <= cntD;
         chkQ     <= chkD;
         tmoQ     <= tmoD;
         errQ     <= errD;
         errCodeQ <= errCodeD;
         rdDataQ  <= bufMem[rd_addr];
      end
   end

   always_ff @(posedge clk) begin
      if (bufWe && !rst) bufMem[cntQ] <= rx_data;
   end

   assign cmd_valid = (stateQ == StHold);
   assign cmd_code  = codeQ;
   assign cmd_len   = lenQ;
   assign rd_data   = rdDataQ;
   assign frame_err = errQ;
   assign err_code  = errCodeQ;
   assign busy      = (stateQ != StIdle);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: stimulus pushes expected commands/errors into a
// scoreboard queue that a negedge monitor pops whenever the DUT reports one.
module tb_uart_cmd_parser;

   localparam int unsigned Tmo = 20;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_data_ready;
   logic [7:0] rx_data;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [7:0] cmd_code;
   logic [4:0] cmd_len;
   logic [3:0] rd_addr;
   logic [7:0] rd_data;
   logic       frame_err;
   logic [1:0] err_code;
   logic       busy;

   typedef struct {
      bit         isErr;
      logic [1:0] code;
      logic [7:0] cmd;
      logic [4:0] len;
   } ev_t;

   typedef logic [7:0] byte_q [$];

   ev_t   expQ [$];
   int    nChecks = 0;
   int    nErrors = 0;
   byte_q seq;

   uart_cmd_parser #(
      .ClkFrequency (100000000),
      .MaxLen       (16),
      .TimeoutCycles(Tmo),
      .Sof          (8'hAA)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .rx_data_ready(rx_data_ready),
      .rx_data      (rx_data),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_code     (cmd_code),
      .cmd_len      (cmd_len),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data),
      .frame_err    (frame_err),
      .err_code     (err_code),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nErrors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic expCmd(input logic [7:0] c, input logic [4:0] l);
      ev_t e;
      e.isErr = 1'b0; e.code = 2'd0; e.cmd = c; e.len = l;
      expQ.push_back(e);
   endtask

   task automatic expErr(input logic [1:0] code);
      ev_t e;
      e.isErr = 1'b1; e.code = code; e.cmd = 8'd0; e.len = 5'd0;
      expQ.push_back(e);
   endtask

   // Called on a negedge; leaves the strobe over exactly one posedge.
   task automatic sendByte(input logic [7:0] b);
      rx_data_ready = 1'b1;
      rx_data       = b;
      @(negedge clk);
      rx_data_ready = 1'b0;
      rx_data       = 8'h00;
   endtask

   task automatic sendSeq(input byte_q s);
      foreach (s[i]) sendByte(s[i]);
   endtask

   task automatic readCheck(input logic [3:0] a, input logic [7:0] exp);
      rd_addr = a;
      @(negedge clk);
      check($sformatf("rd_data[%0d]", a), 32'(rd_data), 32'(exp));
   endtask

   task automatic accept();
      cmd_ready = 1'b1;
      @(negedge clk);
      cmd_ready = 1'b0;
      check("valid_after_accept", 32'(cmd_valid), 32'd0);
      check("busy_after_accept", 32'(busy), 32'd0);
   endtask

   // Monitor: every frame_err pulse and every rising cmd_valid must match the queue head.
   initial begin : monitor
      logic prevValid;
      ev_t  e;
      prevValid = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (frame_err) begin
               if (expQ.size() == 0) begin
                  nChecks++; nErrors++;
                  $display("FAIL unexpected_err: got err_code %0d expected no event", err_code);
               end else begin
                  e = expQ.pop_front();
                  check("event_is_err", 32'(1), 32'(e.isErr));
                  check("err_code", 32'(err_code), 32'(e.code));
               end
            end
            if (cmd_valid && !prevValid) begin
               if (expQ.size() == 0) begin
                  nChecks++; nErrors++;
                  $display("FAIL unexpected_cmd: got cmd 0x%0h expected no event", cmd_code);
               end else begin
                  e = expQ.pop_front();
                  check("event_is_cmd", 32'(0), 32'(e.isErr));
                  check("cmd_code", 32'(cmd_code), 32'(e.cmd));
                  check("cmd_len", 32'(cmd_len), 32'(e.len));
               end
            end
         end
         prevValid = cmd_valid;
      end
   end

   initial begin : stimulus
      rst = 1'b1; rx_data_ready = 1'b0; rx_data = 8'h00; cmd_ready = 1'b0; rd_addr = 4'd0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
      check("rst_cmd_code", 32'(cmd_code), 32'd0);
      check("rst_cmd_len", 32'(cmd_len), 32'd0);
      check("rst_rd_data", 32'(rd_data), 32'd0);
      check("rst_frame_err", 32'(frame_err), 32'd0);
      check("rst_err_code", 32'(err_code), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);

      // Good frame, non-Sof noise first is ignored.
      sendByte(8'h37);
      check("noise_busy", 32'(busy), 32'd0);
      expCmd(8'h10, 5'd3);
      seq = '{8'hAA, 8'h10, 8'h03, 8'h01, 8'h02, 8'h03, 8'h13};
      sendSeq(seq);
      check("good_valid", 32'(cmd_valid), 32'd1);
      check("good_busy", 32'(busy), 32'd1);
      readCheck(4'd0, 8'h01);
      readCheck(4'd1, 8'h02);
      readCheck(4'd2, 8'h03);
      accept();

      // Zero length, then bad checksum.
      expCmd(8'h22, 5'd0);
      seq = '{8'hAA, 8'h22, 8'h00, 8'h22};
      sendSeq(seq);
      check("zlen_valid", 32'(cmd_valid), 32'd1);
      accept();
      expErr(2'd1);
      seq = '{8'hAA, 8'h22, 8'h00, 8'h23};
      sendSeq(seq);
      check("badchk_valid", 32'(cmd_valid), 32'd0);
      check("badchk_busy", 32'(busy), 32'd0);
      check("badchk_code", 32'(err_code), 32'd1);

      // Length error then recovery.
      expErr(2'd2);
      seq = '{8'hAA, 8'h05, 8'h11};
      sendSeq(seq);
      check("lenerr_busy", 32'(busy), 32'd0);
      expCmd(8'h10, 5'd1);
      seq = '{8'hAA, 8'h10, 8'h01, 8'h7F, 8'h6E};
      sendSeq(seq);
      check("recover_valid", 32'(cmd_valid), 32'd1);
      readCheck(4'd0, 8'h7F);
      accept();

      // Overrun while held, then a strobe on the handshake cycle.
      expCmd(8'h33, 5'd2);
      expErr(2'd0);
      seq = '{8'hAA, 8'h33, 8'h02, 8'h5A, 8'hA5, 8'hCE, 8'h55};
      sendSeq(seq);
      check("ovr_code", 32'(err_code), 32'd0);
      check("ovr_valid", 32'(cmd_valid), 32'd1);
      check("ovr_cmd_code", 32'(cmd_code), 32'h33);
      check("ovr_cmd_len", 32'(cmd_len), 32'd2);
      readCheck(4'd0, 8'h5A);
      readCheck(4'd1, 8'hA5);
      expErr(2'd0);
      cmd_ready = 1'b1;
      sendByte(8'h66);
      cmd_ready = 1'b0;
      check("hs_drop_valid", 32'(cmd_valid), 32'd0);
      check("hs_drop_busy", 32'(busy), 32'd0);

      // Inter-byte timeout.
      expErr(2'd3);
      seq = '{8'hAA, 8'h10};
      sendSeq(seq);
      repeat (Tmo - 1) @(negedge clk);
      check("tmo_pre_busy", 32'(busy), 32'd1);
      check("tmo_pre_err", 32'(frame_err), 32'd0);
      @(negedge clk);
      check("tmo_err", 32'(frame_err), 32'd1);
      check("tmo_code", 32'(err_code), 32'd3);
      check("tmo_busy", 32'(busy), 32'd0);

      // Strobe exactly on the terminal cycle keeps the frame alive.
      expCmd(8'h10, 5'd3);
      seq = '{8'hAA, 8'h10};
      sendSeq(seq);
      repeat (Tmo - 1) @(negedge clk);
      sendByte(8'h03);
      check("term_no_err", 32'(frame_err), 32'd0);
      check("term_busy", 32'(busy), 32'd1);
      seq = '{8'h01, 8'h02, 8'h03, 8'h13};
      sendSeq(seq);
      check("term_valid", 32'(cmd_valid), 32'd1);
      accept();

      // Reset mid-payload discards the frame.
      seq = '{8'hAA, 8'h10, 8'h04, 8'h01, 8'h02};
      sendSeq(seq);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mrst_valid", 32'(cmd_valid), 32'd0);
      check("mrst_code", 32'(cmd_code), 32'd0);
      check("mrst_len", 32'(cmd_len), 32'd0);
      check("mrst_rd_data", 32'(rd_data), 32'd0);
      check("mrst_err_code", 32'(err_code), 32'd0);
      check("mrst_busy", 32'(busy), 32'd0);
      expCmd(8'h10, 5'd1);
      seq = '{8'hAA, 8'h10, 8'h01, 8'h7F, 8'h6E};
      sendSeq(seq);
      check("mrst_frame_valid", 32'(cmd_valid), 32'd1);
      readCheck(4'd0, 8'h7F);
      accept();

      repeat (3) @(negedge clk);
      check("scoreboard_empty", 32'(expQ.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
      $finish;
   end

endmodule
